decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter WB_LAT, default 3, range 1..3: cycles a destination register stays busy after issue.
REQ-002 Port clock, input, 1: single clock; all state updates on rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port flush, input, 1: discard current bundle and clear scoreboard.
REQ-005 Port f2d_instpipe1..3, input, 4 each: opcode per slot from fetch; 4'b0000 = nop, 4'b0100 = load.
REQ-006 Port f2d_src1pipe1..3 / f2d_src2pipe1..3, input, 4 each: source register indices per slot.
REQ-007 Port f2d_destpipe1..3, input, 4 each: destination register index per slot.
REQ-008 Port f2d_data, input, 192: load immediate payload for the bundle.
REQ-009 Port stall, output, 1: combinational; upstream holds all f2d_* inputs stable while high.
REQ-010 Port d2e_instpipe1..3 / d2e_src1pipe1..3 / d2e_src2pipe1..3 / d2e_destpipe1..3, output, 4 each: registered issued bundle.
REQ-011 Port d2e_data, output, 192: registered load payload.
REQ-012 Port d_waw, output, 1: registered one-cycle pulse flagging an intra-bundle destination conflict.

Function
REQ-013 Scoreboard: 16 counters of 2 bits each, one per register; counter 0 is never set, so reg0 is always ready.
REQ-014 A slot is active when its opcode is not nop; sources of nop slots are ignored.
REQ-015 stall = ~flush AND (some active slot has counter[src1]!=0 or counter[src2]!=0).
REQ-016 Issue condition: ~flush AND ~stall; on issue, all d2e_* outputs register the f2d_* values one cycle later (latency 1).
REQ-017 On stall, d2e_inst/src/dest outputs register a bubble (all zero), d2e_data registers 0, and the scoreboard only decrements.
REQ-018 Every clock, each nonzero counter decrements by 1, saturating at 0.
REQ-019 On issue, counter[dest] is set to WB_LAT for each active slot with dest != 0; the set takes priority over the decrement for the same register.
REQ-020 Intra-bundle reads take the pre-bundle value: a slot source equal to another slot's destination in the same bundle does not stall.
REQ-021 d2e_data is loaded with f2d_data on issue if any slot opcode is 4'b0100; otherwise it is loaded with 0.
REQ-022 d_waw is set to 1 for one cycle after an issued bundle in which two or more active slots share the same nonzero dest; the bundle still issues.
REQ-023 Flush: the next-edge outputs are a bubble, d2e_data is 0, d_waw is 0, and all counters are cleared; flush overrides stall in the same cycle.
REQ-024 A bundle that stalls for N cycles issues exactly once, on the first cycle its sources are ready; no duplicate and no loss.

Reset
REQ-025 While reset is high, all d2e_* outputs are 0 (nop, reg0), d2e_data is 0, d_waw is 0, and all counters are 0.
REQ-026 Reset asserted mid-stall aborts the held bundle; after release, stall reflects only the current inputs against an empty scoreboard.

Configuration
REQ-027 Macro DECODE_BYPASS_EN, defined: execute forwarding is assumed present, and issue sets counter[dest] to WB_LAT-1 instead of WB_LAT (WB_LAT=1 never busies).
REQ-028 Macro DECODE_BYPASS_EN, undefined: counters are set to WB_LAT as in REQ-019.

Verification
REQ-029 Reset, then bundle {add src1=1 src2=2 dest=3, nop, nop} with WB_LAT=3 -> d2e_instpipe1=0001 and d2e_destpipe1=3 next cycle, stall=0.
REQ-030 Previous bundle followed by {sub src1=3 src2=0 dest=4} held -> stall high for 3 cycles (2 without DECODE_BYPASS_EN? no: 3 without, 2 with), bubbles issued, then sub issues exactly once.
REQ-031 Bundle {load dest=5, add dest=5, nop} with f2d_data=192'hA5.. -> d2e_data=A5.. and d_waw=1 for one cycle.
REQ-032 Stall pending on reg3, then flush=1 for one cycle -> stall=0 in that cycle, bubble output, and the held bundle issues on the following cycle.
REQ-033 Bundle {move src1=7 dest=7, add src1=7 dest=8} with an empty scoreboard -> no stall, both issue, counters 7 and 8 set.
REQ-034 Reset asserted while stalled -> all outputs 0 immediately (asynchronous), stall=0 after release.

Source files
------------

// File: rtl/decode_if.sv
// Fetch-to-decode and decode-to-execute bundle signals for the three-slot decode stage.
interface decode_if;
    logic         flush;
    logic [3:0]   f2d_instpipe1, f2d_instpipe2, f2d_instpipe3;
    logic [3:0]   f2d_src1pipe1, f2d_src1pipe2, f2d_src1pipe3;
    logic [3:0]   f2d_src2pipe1, f2d_src2pipe2, f2d_src2pipe3;
    logic [3:0]   f2d_destpipe1, f2d_destpipe2, f2d_destpipe3;
    logic [191:0] f2d_data;
    logic         stall;
    logic [3:0]   d2e_instpipe1, d2e_instpipe2, d2e_instpipe3;
    logic [3:0]   d2e_src1pipe1, d2e_src1pipe2, d2e_src1pipe3;
    logic [3:0]   d2e_src2pipe1, d2e_src2pipe2, d2e_src2pipe3;
    logic [3:0]   d2e_destpipe1, d2e_destpipe2, d2e_destpipe3;
    logic [191:0] d2e_data;
    logic         d_waw;

    modport master (
        output flush,
        output f2d_instpipe1, f2d_instpipe2, f2d_instpipe3,
        output f2d_src1pipe1, f2d_src1pipe2, f2d_src1pipe3,
        output f2d_src2pipe1, f2d_src2pipe2, f2d_src2pipe3,
        output f2d_destpipe1, f2d_destpipe2, f2d_destpipe3,
        output f2d_data,
        input  stall,
        input  d2e_instpipe1, d2e_instpipe2, d2e_instpipe3,
        input  d2e_src1pipe1, d2e_src1pipe2, d2e_src1pipe3,
        input  d2e_src2pipe1, d2e_src2pipe2, d2e_src2pipe3,
        input  d2e_destpipe1, d2e_destpipe2, d2e_destpipe3,
        input  d2e_data,
        input  d_waw
    );

    modport slave (
        input  flush,
        input  f2d_instpipe1, f2d_instpipe2, f2d_instpipe3,
        input  f2d_src1pipe1, f2d_src1pipe2, f2d_src1pipe3,
        input  f2d_src2pipe1, f2d_src2pipe2, f2d_src2pipe3,
        input  f2d_destpipe1, f2d_destpipe2, f2d_destpipe3,
        input  f2d_data,
        output stall,
        output d2e_instpipe1, d2e_instpipe2, d2e_instpipe3,
        output d2e_src1pipe1, d2e_src1pipe2, d2e_src1pipe3,
        output d2e_src2pipe1, d2e_src2pipe2, d2e_src2pipe3,
        output d2e_destpipe1, d2e_destpipe2, d2e_destpipe3,
        output d2e_data,
        output d_waw
    );
endinterface

// File: rtl/decode.sv
// Three-slot decode stage with a per-register busy-counter scoreboard and RAW stall.
// Optional macro DECODE_BYPASS_EN: execute forwarding present, destinations busy for WB_LAT-1 cycles.
module decode #(
    parameter int unsigned WB_LAT = 3
) (
    input  logic     clock,
    input  logic     reset,
    decode_if.slave  bus
);

    localparam int unsigned NSLOT = 3;
    localparam int unsigned NREG  = 16;
    localparam int unsigned RW    = 4;
    localparam int unsigned CW    = 2;
    localparam int unsigned DW    = 192;
    localparam logic [RW-1:0] OP_NOP  = 4'b0000;
    localparam logic [RW-1:0] OP_LOAD = 4'b0100;

`ifdef DECODE_BYPASS_EN
    localparam logic [CW-1:0] SET_VAL = CW'(WB_LAT - 1);
`else
    localparam logic [CW-1:0] SET_VAL = CW'(WB_LAT);
`endif

    logic [RW-1:0] inst [NSLOT];
    logic [RW-1:0] src1 [NSLOT];
    logic [RW-1:0] src2 [NSLOT];
    logic [RW-1:0] dest [NSLOT];

    logic [RW-1:0] q_inst [NSLOT];
    logic [RW-1:0] q_src1 [NSLOT];
    logic [RW-1:0] q_src2 [NSLOT];
    logic [RW-1:0] q_dest [NSLOT];
    logic [DW-1:0] q_data;
    logic          q_waw;

    logic [CW-1:0] cnt     [NREG];
    logic [CW-1:0] cnt_nxt [NREG];

    logic [NSLOT-1:0] active;
    logic [NREG-1:0]  set_mask;
    logic             hazard;
    logic             issue;
    logic             waw_hit;
    logic             has_load;

    assign inst[0] = bus.f2d_instpipe1;
    assign inst[1] = bus.f2d_instpipe2;
    assign inst[2] = bus.f2d_instpipe3;
    assign src1[0] = bus.f2d_src1pipe1;
    assign src1[1] = bus.f2d_src1pipe2;
    assign src1[2] = bus.f2d_src1pipe3;
    assign src2[0] = bus.f2d_src2pipe1;
    assign src2[1] = bus.f2d_src2pipe2;
    assign src2[2] = bus.f2d_src2pipe3;
    assign dest[0] = bus.f2d_destpipe1;
    assign dest[1] = bus.f2d_destpipe2;
    assign dest[2] = bus.f2d_destpipe3;

    // Hazard check reads the pre-bundle scoreboard, so intra-bundle producers never stall consumers.
    always_comb begin
        active   = '0;
        hazard   = 1'b0;
        waw_hit  = 1'b0;
        has_load = 1'b0;
        set_mask = '0;
        for (int i = 0; i < NSLOT; i++) begin
            active[i] = (inst[i] != OP_NOP);
            if (inst[i] == OP_LOAD) has_load = 1'b1;
        end
        for (int i = 0; i < NSLOT; i++) begin
            if (active[i] && ((cnt[src1[i]] != '0) || (cnt[src2[i]] != '0))) hazard = 1'b1;
            if (active[i] && (dest[i] != '0)) set_mask[dest[i]] = 1'b1;
            for (int j = i + 1; j < NSLOT; j++) begin
                if (active[i] && active[j] && (dest[i] != '0) && (dest[i] == dest[j])) waw_hit = 1'b1;
            end
        end
    end

    assign bus.stall = ~bus.flush & hazard;
    assign issue     = ~bus.flush & ~hazard;

    // Issue-time set wins over the per-cycle decrement; flush wipes everything.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt[r] = '0;
            if (bus.flush) begin
                cnt_nxt[r] = '0;
            end else if (issue && set_mask[r]) begin
                cnt_nxt[r] = SET_VAL;
            end else if (cnt[r] != '0) begin
                cnt_nxt[r] = cnt[r] - CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                q_inst[i] <= '0;
                q_src1[i] <= '0;
                q_src2[i] <= '0;
                q_dest[i] <= '0;
            end
            q_data <= '0;
            q_waw  <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
            for (int i = 0; i < NSLOT; i++) begin
                q_inst[i] <= issue ? inst[i] : '0;
                q_src1[i] <= issue ? src1[i] : '0;
                q_src2[i] <= issue ? src2[i] : '0;
                q_dest[i] <= issue ? dest[i] : '0;
            end
            q_data <= (issue && has_load) ? bus.f2d_data : '0;
            q_waw  <= issue & waw_hit;
        end
    end

    assign bus.d2e_instpipe1 = q_inst[0];
    assign bus.d2e_instpipe2 = q_inst[1];
    assign bus.d2e_instpipe3 = q_inst[2];
    assign bus.d2e_src1pipe1 = q_src1[0];
    assign bus.d2e_src1pipe2 = q_src1[1];
    assign bus.d2e_src1pipe3 = q_src1[2];
    assign bus.d2e_src2pipe1 = q_src2[0];
    assign bus.d2e_src2pipe2 = q_src2[1];
    assign bus.d2e_src2pipe3 = q_src2[2];
    assign bus.d2e_destpipe1 = q_dest[0];
    assign bus.d2e_destpipe2 = q_dest[1];
    assign bus.d2e_destpipe3 = q_dest[2];
    assign bus.d2e_data      = q_data;
    assign bus.d_waw         = q_waw;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: busy-until-cycle reference model, expected outputs queued per edge.
module tb_decode;

    localparam int WB_LAT = 3;
`ifdef DECODE_BYPASS_EN
    localparam int SET_LAT = WB_LAT - 1;
`else
    localparam int SET_LAT = WB_LAT;
`endif

    typedef struct {
        logic [47:0]  bundle;
        logic [191:0] data;
        logic         waw;
    } exp_t;

    logic clock;
    logic reset;
    decode_if bus();

    decode #(.WB_LAT(WB_LAT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   busy_until [16];
    exp_t exp_q [$];

    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [47:0] pack_in();
        return {bus.f2d_instpipe1, bus.f2d_instpipe2, bus.f2d_instpipe3,
                bus.f2d_src1pipe1, bus.f2d_src1pipe2, bus.f2d_src1pipe3,
                bus.f2d_src2pipe1, bus.f2d_src2pipe2, bus.f2d_src2pipe3,
                bus.f2d_destpipe1, bus.f2d_destpipe2, bus.f2d_destpipe3};
    endfunction

    function automatic logic [47:0] pack_out();
        return {bus.d2e_instpipe1, bus.d2e_instpipe2, bus.d2e_instpipe3,
                bus.d2e_src1pipe1, bus.d2e_src1pipe2, bus.d2e_src1pipe3,
                bus.d2e_src2pipe1, bus.d2e_src2pipe2, bus.d2e_src2pipe3,
                bus.d2e_destpipe1, bus.d2e_destpipe2, bus.d2e_destpipe3};
    endfunction

    function automatic bit reg_busy(input logic [3:0] r);
        return (r != 4'd0) && (busy_until[r] >= cyc);
    endfunction

    // Reference: a register is busy through cycle busy_until, i.e. the SET_LAT cycles after issue.
    task automatic run_cycle(output bit issued);
        logic [3:0] op [3];
        logic [3:0] s1 [3];
        logic [3:0] s2 [3];
        logic [3:0] d  [3];
        int   seen [16];
        bit   st, iss, ld, dup;
        exp_t e;
        @(negedge clock);
        op = '{bus.f2d_instpipe1, bus.f2d_instpipe2, bus.f2d_instpipe3};
        s1 = '{bus.f2d_src1pipe1, bus.f2d_src1pipe2, bus.f2d_src1pipe3};
        s2 = '{bus.f2d_src2pipe1, bus.f2d_src2pipe2, bus.f2d_src2pipe3};
        d  = '{bus.f2d_destpipe1, bus.f2d_destpipe2, bus.f2d_destpipe3};
        st = 0; ld = 0; dup = 0;
        foreach (seen[r]) seen[r] = 0;
        for (int k = 0; k < 3; k++) begin
            if (op[k] != 4'd0) begin
                if (reg_busy(s1[k]) || reg_busy(s2[k])) st = 1;
                if (op[k] == 4'b0100) ld = 1;
                if (d[k] != 4'd0) begin
                    seen[d[k]]++;
                    if (seen[d[k]] > 1) dup = 1;
                end
            end
        end
        if (bus.flush) st = 0;
        check_eq("stall", bus.stall, st);
        iss      = !bus.flush && !st;
        e.bundle = iss ? pack_in() : 48'd0;
        e.data   = (iss && ld) ? bus.f2d_data : 192'd0;
        e.waw    = iss && dup;
        exp_q.push_back(e);
        if (bus.flush) begin
            foreach (busy_until[r]) busy_until[r] = -1;
        end else if (iss) begin
            for (int k = 0; k < 3; k++)
                if (op[k] != 4'd0 && d[k] != 4'd0) busy_until[d[k]] = cyc + SET_LAT;
        end
        @(posedge clock);
        #1;
        cyc++;
        e = exp_q.pop_front();
        check_eq("bundle", pack_out(), e.bundle);
        check_eq("data", bus.d2e_data, e.data);
        check_eq("waw", bus.d_waw, e.waw);
        issued = iss;
    endtask

    task automatic send(output int stalls);
        bit iss;
        stalls = 0;
        iss = 0;
        for (int k = 0; k < 40 && !iss; k++) begin
            run_cycle(iss);
            if (!iss) stalls++;
        end
        check_eq("issue_bound", iss, 1'b1);
    endtask

    task automatic clear_bundle();
        bus.flush = 0;
        bus.f2d_instpipe1 = 0; bus.f2d_instpipe2 = 0; bus.f2d_instpipe3 = 0;
        bus.f2d_src1pipe1 = 0; bus.f2d_src1pipe2 = 0; bus.f2d_src1pipe3 = 0;
        bus.f2d_src2pipe1 = 0; bus.f2d_src2pipe2 = 0; bus.f2d_src2pipe3 = 0;
        bus.f2d_destpipe1 = 0; bus.f2d_destpipe2 = 0; bus.f2d_destpipe3 = 0;
        bus.f2d_data = '0;
    endtask

    task automatic set_slot(input int k, input logic [3:0] op, input logic [3:0] s1,
                            input logic [3:0] s2, input logic [3:0] d);
        case (k)
            0: begin bus.f2d_instpipe1 = op; bus.f2d_src1pipe1 = s1; bus.f2d_src2pipe1 = s2; bus.f2d_destpipe1 = d; end
            1: begin bus.f2d_instpipe2 = op; bus.f2d_src1pipe2 = s1; bus.f2d_src2pipe2 = s2; bus.f2d_destpipe2 = d; end
            default: begin bus.f2d_instpipe3 = op; bus.f2d_src1pipe3 = s1; bus.f2d_src2pipe3 = s2; bus.f2d_destpipe3 = d; end
        endcase
    endtask

    initial begin
        int  stalls;
        bit  iss;
        bit  held;
        foreach (busy_until[r]) busy_until[r] = -1;
        clear_bundle();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_eq("reset_bundle", pack_out(), 48'd0);
        check_eq("reset_data", bus.d2e_data, 192'd0);
        check_eq("reset_waw", bus.d_waw, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // add r1,r2 -> r3 issues with latency one
        set_slot(0, 4'b0001, 4'd1, 4'd2, 4'd3);
        send(stalls);
        check_eq("add_stalls", stalls, 0);
        check_eq("add_inst1", bus.d2e_instpipe1, 4'b0001);
        check_eq("add_dest1", bus.d2e_destpipe1, 4'd3);

        // sub reads r3 right behind its producer
        clear_bundle();
        set_slot(0, 4'b0010, 4'd3, 4'd0, 4'd4);
        send(stalls);
        check_eq("sub_stalls", stalls, SET_LAT);
        check_eq("sub_inst1", bus.d2e_instpipe1, 4'b0010);

        // load + add both writing r5
        clear_bundle();
        set_slot(0, 4'b0100, 4'd0, 4'd0, 4'd5);
        set_slot(1, 4'b0001, 4'd0, 4'd0, 4'd5);
        bus.f2d_data = {24{8'hA5}};
        send(stalls);
        check_eq("waw_pulse", bus.d_waw, 1'b1);
        check_eq("load_data", bus.d2e_data, {24{8'hA5}});
        clear_bundle();
        run_cycle(iss);
        check_eq("waw_drop", bus.d_waw, 1'b0);

        // flush while a hazard on r3 is pending
        set_slot(0, 4'b0001, 4'd0, 4'd0, 4'd3);
        send(stalls);
        clear_bundle();
        set_slot(0, 4'b0001, 4'd3, 4'd0, 4'd9);
        bus.flush = 1;
        run_cycle(iss);
        bus.flush = 0;
        run_cycle(iss);
        check_eq("held_after_flush", bus.d2e_destpipe1, 4'd9);

        // intra-bundle read of a same-bundle destination
        clear_bundle();
        bus.flush = 1;
        run_cycle(iss);
        clear_bundle();
        set_slot(0, 4'b0011, 4'd7, 4'd0, 4'd7);
        set_slot(1, 4'b0001, 4'd7, 4'd0, 4'd8);
        send(stalls);
        check_eq("intra_stalls", stalls, 0);
        check_eq("intra_dest2", bus.d2e_destpipe2, 4'd8);
        clear_bundle();
        set_slot(2, 4'b0001, 4'd8, 4'd7, 4'd1);
        send(stalls);
        check_eq("r8_busy_stalls", stalls, SET_LAT);

        // random bundles, held while stalled, occasional flush
        held = 0;
        for (int n = 0; n < 300; n++) begin
            if (!held) begin
                for (int k = 0; k < 3; k++)
                    set_slot(k, ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                             4'($urandom_range(0, 15)));
                bus.f2d_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            end
            bus.flush = ($urandom_range(0, 9) == 0);
            run_cycle(iss);
            held = !iss && !bus.flush;
        end

        // asynchronous reset in the middle of a stall
        clear_bundle();
        set_slot(0, 4'b0001, 4'd0, 4'd0, 4'd3);
        send(stalls);
        clear_bundle();
        set_slot(0, 4'b0010, 4'd3, 4'd0, 4'd4);
        @(negedge clock);
        check_eq("pre_reset_stall", bus.stall, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst_bundle", pack_out(), 48'd0);
        check_eq("async_rst_data", bus.d2e_data, 192'd0);
        check_eq("async_rst_waw", bus.d_waw, 1'b0);
        foreach (busy_until[r]) busy_until[r] = -1;
        @(negedge clock);
        reset = 1'b0;
        run_cycle(iss);
        check_eq("post_reset_issue", bus.d2e_instpipe1, 4'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
